// File: rtl/vga_palette_pkg.sv
// Purpose: shared palette constants, host write record type, FSM states, default colour set.
// Latency: n/a (declarations and a pure function only).
// Backpressure: n/a.
package vga_palette_pkg;

  localparam int PAL_ENTRIES = 16;
  localparam int IDX_W       = 4;
  localparam int RGB_W       = 12;

  // One queued host write: palette slot plus {R,G,B} nibbles.
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [RGB_W-1:0] rgb;
  } pal_wr_t;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_IDLE = 1'b1
  } pal_state_t;

  // Standard 16-colour text-mode set, shared with the fixed palette.
  function automatic logic [RGB_W-1:0] default_rgb(input logic [IDX_W-1:0] idx);
    logic [RGB_W-1:0] c;
    case (idx)
      4'd0:    c = 12'h000;
      4'd1:    c = 12'h00A;
      4'd2:    c = 12'h0A0;
      4'd3:    c = 12'h0AA;
      4'd4:    c = 12'hA00;
      4'd5:    c = 12'hA0A;
      4'd6:    c = 12'hA50;
      4'd7:    c = 12'hAAA;
      4'd8:    c = 12'h555;
      4'd9:    c = 12'h55F;
      4'd10:   c = 12'h5F5;
      4'd11:   c = 12'h5FF;
      4'd12:   c = 12'hF55;
      4'd13:   c = 12'hF5F;
      4'd14:   c = 12'hFF5;
      default: c = 12'hFFF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/palette_wr_fifo.sv
// Purpose: in-order queue of pending palette writes {index, rgb}.
// Latency: head shows the oldest entry combinationally from registered pointers; count is registered.
// Backpressure: none internally; the parent never pushes when full or pops when empty.
// Ports: clk, reset (sync, active-high), push + din, pop, head (oldest entry), count (occupancy).
module palette_wr_fifo
  import vga_palette_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  pal_wr_t                din,
  input  logic                   pop,
  output pal_wr_t                head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pal_wr_t         mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/palette_ctrl.sv
// Purpose: writable 16-entry text palette; host writes queue and commit only in blanking; default loader.
// Latency: fg/bg to R/G/B 1 cycle; write accepted at T is visible to the lookup at T+2 at the earliest.
// Backpressure: wr_ready = registered occupancy below FIFO_DEPTH; independent of wr_valid.
// Ports: clk, reset; host wr_valid/wr_ready/wr_index/wr_rgb; load_defaults pulse; blank;
//        busy (default load running); pending (queued writes); fg/bg indices in; R/G/B {fg,bg} nibbles out.
module palette_ctrl
  import vga_palette_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [IDX_W-1:0]            wr_index,
  input  logic [RGB_W-1:0]            wr_rgb,
  input  logic                        load_defaults,
  input  logic                        blank,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  input  logic [IDX_W-1:0]            fg,
  input  logic [IDX_W-1:0]            bg,
  output logic [7:0]                  R,
  output logic [7:0]                  G,
  output logic [7:0]                  B
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  pal_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             load_we;
  logic             push;
  logic             commit;
  pal_wr_t          din;
  pal_wr_t          head;
  logic [RGB_W-1:0] pal [PAL_ENTRIES];
  logic [RGB_W-1:0] pal_fg;
  logic [RGB_W-1:0] pal_bg;

  // ---------------- write queue ----------------
  assign wr_ready = (pending < CNT_W'(FIFO_DEPTH));
  assign push     = wr_valid && wr_ready;
  assign din      = '{index: wr_index, rgb: wr_rgb};
  assign commit   = (state == ST_IDLE) && blank && (pending != '0);

  palette_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (commit),
    .head  (head),
    .count (pending)
  );

  // ---------------- load sequencer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // load_defaults is only honoured from IDLE, so a pulse mid-load never restarts the count.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_we   = 1'b0;
    case (state)
      ST_LOAD: begin
        load_we = 1'b1;
        idx_nxt = idx + IDX_W'(1);
        if (idx == IDX_W'(PAL_ENTRIES - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (load_defaults) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        idx_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == ST_LOAD);

  // ---------------- palette storage ----------------
  // Loader and commit are mutually exclusive by state, so one write port suffices.
  always_ff @(posedge clk) begin
    if (load_we)     pal[idx]        <= default_rgb(idx);
    else if (commit) pal[head.index] <= head.rgb;
  end

  // ---------------- lookup ----------------
  // Reads the pre-edge palette, so a same-edge commit shows up one cycle later.
  assign pal_fg = pal[fg];
  assign pal_bg = pal[bg];

  always_ff @(posedge clk) begin
    if (reset || busy) begin
      R <= '0;
      G <= '0;
      B <= '0;
    end else begin
      R <= {pal_fg[11:8], pal_bg[11:8]};
      G <= {pal_fg[7:4],  pal_bg[7:4]};
      B <= {pal_fg[3:0],  pal_bg[3:0]};
    end
  end

endmodule

// File: tb/tb_palette_ctrl.sv
// Purpose: self-checking bench for palette_ctrl: constant lookup table, directed corner sequences,
//          random traffic against a queue/array reference model.
// Latency: n/a. Backpressure: n/a.
module tb_palette_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_index = '0;
  logic [11:0] wr_rgb = '0;
  logic       load_defaults = 1'b0;
  logic       blank = 1'b0;
  logic       busy;
  logic [2:0] pending;
  logic [3:0] fg = '0;
  logic [3:0] bg = '0;
  logic [7:0] R, G, B;

  int checks = 0;
  int errors = 0;

  palette_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_index      (wr_index),
    .wr_rgb        (wr_rgb),
    .load_defaults (load_defaults),
    .blank         (blank),
    .busy          (busy),
    .pending       (pending),
    .fg            (fg),
    .bg            (bg),
    .R             (R),
    .G             (G),
    .B             (B)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [11:0] def_tab [16];
  logic [11:0] m_pal [16];
  logic [15:0] m_q [$];
  int          m_load_left;   // default-table writes still to do; >0 means loading
  logic [7:0]  m_r, m_g, m_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge of the behaviour to the model, using the inputs the DUT also sees.
  task automatic model_edge();
    logic        loading;
    logic        can_take;
    logic [15:0] e;
    logic [11:0] pf, pb;
    int          n;
    if (reset) begin
      m_q.delete();
      m_load_left = 16;
      m_r = '0; m_g = '0; m_b = '0;
    end else begin
      loading  = (m_load_left > 0);
      n        = m_q.size();
      can_take = (n < DEPTH);
      if (loading) begin
        m_r = '0; m_g = '0; m_b = '0;
      end else begin
        pf = m_pal[fg];
        pb = m_pal[bg];
        m_r = {pf[11:8], pb[11:8]};
        m_g = {pf[7:4],  pb[7:4]};
        m_b = {pf[3:0],  pb[3:0]};
      end
      if (!loading && blank && n > 0) begin
        e = m_q.pop_front();
        m_pal[e[15:12]] = e[11:0];
      end
      if (loading) begin
        m_pal[16 - m_load_left] = def_tab[16 - m_load_left];
        m_load_left--;
      end else if (load_defaults) begin
        m_load_left = 16;
      end
      if (wr_valid && can_take) m_q.push_back({wr_index, wr_rgb});
    end
  endtask

  // One clock: model and DUT advance together, outputs compared 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy",     32'(busy),     32'(m_load_left > 0));
    chk("pending",  32'(pending),  32'(m_q.size()));
    chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
    chk("R", 32'(R), 32'(m_r));
    chk("G", 32'(G), 32'(m_g));
    chk("B", 32'(B), 32'(m_b));
  endtask

  task automatic host_write(input logic [3:0] i, input logic [11:0] c);
    wr_valid = 1'b1;
    wr_index = i;
    wr_rgb   = c;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic expect_rgb(input string name, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    chk({name, ".R"}, 32'(R), 32'(r));
    chk({name, ".G"}, 32'(G), 32'(g));
    chk({name, ".B"}, 32'(B), 32'(b));
  endtask

  typedef struct {
    logic [3:0] fg;
    logic [3:0] bg;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;

    def_tab = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
                12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
    for (int i = 0; i < 16; i++) m_pal[i] = '0;
    m_load_left = 16;
    m_r = '0; m_g = '0; m_b = '0;

    // Lookups of the default set, worked out by hand from the colour table.
    vecs[0] = '{fg: 4'd4,  bg: 4'd1,  r: 8'hA0, g: 8'h00, b: 8'h0A};
    vecs[1] = '{fg: 4'd6,  bg: 4'd0,  r: 8'hA0, g: 8'h50, b: 8'h00};
    vecs[2] = '{fg: 4'd15, bg: 4'd0,  r: 8'hF0, g: 8'hF0, b: 8'hF0};
    vecs[3] = '{fg: 4'd9,  bg: 4'd12, r: 8'h5F, g: 8'h55, b: 8'hF5};
    vecs[4] = '{fg: 4'd2,  bg: 4'd7,  r: 8'h0A, g: 8'hAA, b: 8'h0A};
    vecs[5] = '{fg: 4'd13, bg: 4'd10, r: 8'hF5, g: 8'h5F, b: 8'hF5};
    vecs[6] = '{fg: 4'd3,  bg: 4'd8,  r: 8'h05, g: 8'hA5, b: 8'hA5};
    vecs[7] = '{fg: 4'd11, bg: 4'd14, r: 8'h5F, g: 8'hFF, b: 8'hF5};

    // ---- reset state ----
    tick();
    reset = 1'b0;
    chk("rst.busy", 32'(busy), 32'd1);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.wr_ready", 32'(wr_ready), 32'd1);
    expect_rgb("rst", 8'h00, 8'h00, 8'h00);

    // ---- default load length ----
    count_busy(n);
    chk("load_cycles", 32'(n), 32'd16);

    // ---- default table lookups ----
    for (int k = 0; k < 8; k++) begin
      fg = vecs[k].fg;
      bg = vecs[k].bg;
      tick();
      expect_rgb($sformatf("vec%0d", k), vecs[k].r, vecs[k].g, vecs[k].b);
    end

    // ---- deferred commit ----
    blank = 1'b0;
    host_write(4'd4, 12'h123);
    chk("defer.pending", 32'(pending), 32'd1);
    fg = 4'd4; bg = 4'd0;
    tick();
    expect_rgb("defer.hidden", 8'hA0, 8'h00, 8'h00);
    blank = 1'b1;
    tick();
    chk("defer.drained", 32'(pending), 32'd0);
    expect_rgb("defer.rbw", 8'hA0, 8'h00, 8'h00);
    tick();
    expect_rgb("defer.visible", 8'h10, 8'h20, 8'h30);
    blank = 1'b0;

    // ---- full queue backpressure ----
    for (int k = 0; k < 4; k++) host_write(4'(8 + k), 12'h111 * 12'(k + 1));
    chk("full.pending", 32'(pending), 32'd4);
    chk("full.wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_index = 4'd12; wr_rgb = 12'h555;
    tick();
    chk("full.held", 32'(pending), 32'd4);
    // wr_ready is a registered full flag: the held write enters one edge after the first pop.
    blank = 1'b1;
    tick();
    chk("drain.first_pop", 32'(pending), 32'd3);
    chk("drain.ready", 32'(wr_ready), 32'd1);
    tick();
    chk("drain.push_pop", 32'(pending), 32'd3);
    wr_valid = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      tick();
      chk("drain.step", 32'(pending), 32'(k));
    end
    blank = 1'b0;
    fg = 4'd12; bg = 4'd8;
    tick();
    expect_rgb("drain.values", 8'h51, 8'h51, 8'h51);

    // ---- duplicate index: last write wins ----
    host_write(4'd7, 12'hF00);
    host_write(4'd7, 12'h0F0);
    blank = 1'b1;
    tick();
    tick();
    chk("dup.pending", 32'(pending), 32'd0);
    blank = 1'b0;
    fg = 4'd7; bg = 4'd0;
    tick();
    chk("dup.R_hi", 32'(R[7:4]), 32'h0);
    chk("dup.G_hi", 32'(G[7:4]), 32'hF);

    // ---- queue survives a default reload ----
    host_write(4'd1, 12'h321);
    host_write(4'd14, 12'h456);
    load_defaults = 1'b1;
    tick();
    load_defaults = 1'b0;
    blank = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      load_defaults = (n == 5);   // ignored while loading
      tick();
      load_defaults = 1'b0;
      chk("reload.pending", 32'(pending), 32'd2);
      n++;
    end
    chk("reload.cycles", 32'(n), 32'd16);
    tick();
    tick();
    chk("reload.drained", 32'(pending), 32'd0);
    fg = 4'd1; bg = 4'd14;
    tick();
    expect_rgb("reload.host_wins", 8'h34, 8'h25, 8'h16);
    blank = 1'b0;

    // ---- reset in the middle of a drain ----
    for (int k = 0; k < 4; k++) host_write(4'(k), 12'hABC);
    blank = 1'b1;
    tick();
    chk("mid.pending", 32'(pending), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid.flushed", 32'(pending), 32'd0);
    chk("mid.busy", 32'(busy), 32'd1);
    expect_rgb("mid.rgb0", 8'h00, 8'h00, 8'h00);
    count_busy(n);
    chk("mid.load_cycles", 32'(n), 32'd16);
    blank = 1'b0;
    fg = 4'd4; bg = 4'd1;
    tick();
    expect_rgb("mid.def41", 8'hA0, 8'h00, 8'h0A);
    fg = 4'd0; bg = 4'd3;
    tick();
    expect_rgb("mid.def03", 8'h00, 8'h0A, 8'h0A);

    // ---- random traffic against the model ----
    for (int c = 0; c < 800; c++) begin
      wr_valid      = 1'($urandom_range(0, 1));
      wr_index      = 4'($urandom_range(0, 15));
      wr_rgb        = 12'($urandom_range(0, 4095));
      blank         = ($urandom_range(0, 2) != 0);
      load_defaults = ($urandom_range(0, 63) == 0);
      fg            = 4'($urandom_range(0, 15));
      bg            = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
